// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, hex-to-seven-segment decode and parameter legality checks
// for the multiplexed seven-segment display path.
package seg7_scan_driver_pkg;

    localparam int unsigned SEG_W        = 7;
    localparam int unsigned MIN_DIGITS   = 2;
    localparam int unsigned MAX_DIGITS   = 8;
    localparam int unsigned MIN_PRESCALE = 2;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; also used by the binary-to-7seg decoder.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    function automatic bit params_legal(input int unsigned num_digits,
                                        input int unsigned prescale,
                                        input int unsigned blank_cycles);
        return (num_digits >= MIN_DIGITS) && (num_digits <= MAX_DIGITS) &&
               (prescale >= MIN_PRESCALE) && (blank_cycles < prescale);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side load bus and display-side outputs of the seven-segment scan driver.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_start;

    modport master (
        output enable, load, digits_in, dp_in, blank_lz,
        input  seg_out, dp_out, dig_en, frame_start
    );

    modport slave (
        input  enable, load, digits_in, dp_in, blank_lz,
        output seg_out, dp_out, dig_en, frame_start
    );
endinterface

// File: rtl/seg7_scan_timer.sv
// Slot prescaler and digit index counters with blank-window and frame-wrap flags.
module seg7_scan_timer #(
    parameter  int unsigned NUM_DIGITS   = 4,
    parameter  int unsigned PRESCALE     = 50000,
    parameter  int unsigned BLANK_CYCLES = 16,
    localparam int unsigned PS_W         = $clog2(PRESCALE),
    localparam int unsigned IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             enable,
    output logic [IDX_W-1:0] index,
    output logic             in_blank_c,
    output logic             frame_wrap_c
);
    logic [PS_W-1:0] count;
    logic            slot_wrap_c;

    assign slot_wrap_c  = enable && (count == PS_W'(PRESCALE - 1));
    assign frame_wrap_c = slot_wrap_c && (index == IDX_W'(NUM_DIGITS - 1));
    assign in_blank_c   = (count < PS_W'(BLANK_CYCLES));

    // Counters freeze while disabled so scanning resumes mid-slot.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
            index <= '0;
        end else if (enable) begin
            if (slot_wrap_c) begin
                count <= '0;
                index <= frame_wrap_c ? '0 : index + IDX_W'(1);
            end else begin
                count <= count + PS_W'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered digit word, dead-time
// blanking between slots and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic          clk,
    input  logic          clr_n,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    if (!params_legal(NUM_DIGITS, PRESCALE, BLANK_CYCLES)) begin : g_bad_params
        $error("seg7_scan_driver: illegal NUM_DIGITS/PRESCALE/BLANK_CYCLES");
    end

    typedef logic [NUM_DIGITS-1:0][3:0] nibs_t;

    logic [IDX_W-1:0]      index;
    logic                  in_blank_c;
    logic                  frame_wrap_c;
    nibs_t                 shadow_digits;
    nibs_t                 disp_digits;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic                  load_pending;
    logic [NUM_DIGITS-1:0] lz_blank_c;

    seg7_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .clr_n        (clr_n),
        .enable       (bus.enable),
        .index        (index),
        .in_blank_c   (in_blank_c),
        .frame_wrap_c (frame_wrap_c)
    );

    // Display copies the older shadow at frame wrap; a coincident load stays pending.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            disp_digits   <= '0;
            disp_dp       <= '0;
            load_pending  <= 1'b0;
        end else begin
            if (frame_wrap_c && load_pending) begin
                disp_digits <= shadow_digits;
                disp_dp     <= shadow_dp;
            end
            if (bus.load) begin
                shadow_digits <= nibs_t'(bus.digits_in);
                shadow_dp     <= bus.dp_in;
                load_pending  <= 1'b1;
            end else if (frame_wrap_c) begin
                load_pending  <= 1'b0;
            end
        end
    end

    // Digit i is suppressed when it and every more-significant nibble are zero.
    always_comb begin : lz_mask
        logic run;
        run        = bus.blank_lz;
        lz_blank_c = '0;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            run           = run && (disp_digits[i] == 4'h0);
            lz_blank_c[i] = run;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus.seg_out     <= SEG_BLANK;
            bus.dp_out      <= 1'b1;
            bus.dig_en      <= '1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= frame_wrap_c;
            if (!bus.enable || in_blank_c) begin
                bus.seg_out <= SEG_BLANK;
                bus.dp_out  <= 1'b1;
                bus.dig_en  <= '1;
            end else begin
                bus.seg_out <= lz_blank_c[index] ? SEG_BLANK : hex_to_seg(disp_digits[index]);
                bus.dp_out  <= ~disp_dp[index];
                bus.dig_en  <= ~(NUM_DIGITS'(1) << index);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: vector table, directed corner sequences and
// randomized traffic against a time-position reference model.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int PS    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * PS;

    logic clk;
    logic clr_n;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus();

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [16];

    // Reference model: t counts enabled cycles since reset.
    int         t;
    logic [15:0] shadow, disp;
    logic [3:0]  shadow_dp, disp_dp;
    logic        pending;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_dig;
    logic        exp_fs;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
        logic [27:0] segs;
        logic [3:0]  dp_out;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    function automatic void model_reset();
        t = 0; shadow = '0; disp = '0; shadow_dp = '0; disp_dp = '0; pending = 1'b0;
        exp_seg = 7'h7F; exp_dp = 1'b1; exp_dig = 4'hF; exp_fs = 1'b0;
    endfunction

    function automatic void model_edge();
        int p, idx;
        logic lz;
        if (bus.enable) begin
            p   = t % PS;
            idx = (t / PS) % ND;
            if (p < BC) begin
                exp_seg = 7'h7F; exp_dp = 1'b1; exp_dig = 4'hF;
            end else begin
                exp_dig      = 4'hF;
                exp_dig[idx] = 1'b0;
                lz = bus.blank_lz && (idx > 0);
                for (int j = idx; j < ND; j++) if (disp[4*j +: 4] != 4'h0) lz = 1'b0;
                exp_seg = lz ? 7'h7F : seg_tbl[disp[4*idx +: 4]];
                exp_dp  = ~disp_dp[idx];
            end
            t++;
            exp_fs = ((t % FRAME) == 0);
            if (exp_fs && pending) begin
                disp = shadow; disp_dp = shadow_dp; pending = 1'b0;
            end
        end else begin
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_dig = 4'hF; exp_fs = 1'b0;
        end
        if (bus.load) begin
            shadow = bus.digits_in; shadow_dp = bus.dp_in; pending = 1'b1;
        end
    endfunction

    task automatic cmp_model();
        chk("seg_out",     32'(bus.seg_out),     32'(exp_seg));
        chk("dp_out",      32'(bus.dp_out),      32'(exp_dp));
        chk("dig_en",      32'(bus.dig_en),      32'(exp_dig));
        chk("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic wait_t(input int m, input int r);
        int n = 0;
        while (((t % m) != r) && (n < 2 * FRAME)) begin
            step();
            n++;
        end
        chk("wait_position", 32'(t % m), 32'(r));
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            step();
            n++;
        end while (!exp_fs && (n < FRAME + 8));
        chk("frame_wait", 32'(bus.frame_start), 32'(1));
    endtask

    task automatic scan_vec(input vec_t v);
        int d;
        bus.digits_in = v.digits; bus.dp_in = v.dp; bus.blank_lz = v.lz; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        wait_frame();
        for (int k = 1; k <= FRAME; k++) begin
            step();
            d = (k - 1) / PS;
            if (((k - 1) % PS) == 3) begin
                chk("vec_dig_en", 32'(bus.dig_en), 32'(4'hF & ~(4'h1 << d)));
                chk("vec_seg",    32'(bus.seg_out), 32'(v.segs[7*d +: 7]));
                chk("vec_dp",     32'(bus.dp_out),  32'(v.dp_out[d]));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0] = '{16'h12A4, 4'b0010, 1'b0, {7'h79, 7'h24, 7'h08, 7'h19}, 4'b1101};
        vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'hFEDC, 4'b1001, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h46}, 4'b0110};
        vecs[4] = '{16'h0300, 4'b1000, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'b0111};

        clr_n = 1'b1;
        bus.enable = 1'b1; bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
        #1 clr_n = 1'b0;
        model_reset();
        #1;
        chk("rst_seg",   32'(bus.seg_out),     32'(7'h7F));
        chk("rst_dp",    32'(bus.dp_out),      32'(1));
        chk("rst_dig",   32'(bus.dig_en),      32'(4'hF));
        chk("rst_fs",    32'(bus.frame_start), 32'(0));
        @(negedge clk);
        clr_n = 1'b1;

        // Zero display after reset, blank window then digit 0, frame pulse every 32.
        for (int k = 1; k <= 2 * FRAME; k++) begin
            step();
            if (k <= 9)
                chk("t1_dig_en", 32'(bus.dig_en), 32'((k <= BC || k == 9) ? 4'hF : 4'hE));
            if (k > BC && k <= PS)
                chk("t1_seg", 32'(bus.seg_out), 32'(7'h40));
            if (k == FRAME || k == 2 * FRAME)
                chk("t1_frame_start", 32'(bus.frame_start), 32'(1));
        end

        for (int i = 0; i < 5; i++) scan_vec(vecs[i]);

        // Second load lands on the apply cycle: older data shows first.
        bus.blank_lz = 1'b0; bus.dp_in = '0;
        wait_t(FRAME, 10);
        bus.digits_in = 16'h1111; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        wait_t(FRAME, FRAME - 1);
        bus.digits_in = 16'h2222; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("t4_fs1", 32'(bus.frame_start), 32'(1));
        for (int k = 1; k <= FRAME; k++) begin
            step();
            if (k == 4)     chk("t4_old_data", 32'(bus.seg_out), 32'(7'h79));
            if (k == FRAME) chk("t4_fs2", 32'(bus.frame_start), 32'(1));
        end
        for (int k = 1; k <= 4; k++) step();
        chk("t4_new_data", 32'(bus.seg_out), 32'(7'h24));

        // Enable dropped at index 2, count 5.
        wait_t(FRAME, 2 * PS + 5);
        bus.enable = 1'b0;
        step();
        chk("t5_off_dig", 32'(bus.dig_en),  32'(4'hF));
        chk("t5_off_seg", 32'(bus.seg_out), 32'(7'h7F));
        for (int k = 0; k < 9; k++) step();
        bus.enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t5_resume_dig", 32'(bus.dig_en), 32'((k <= 3) ? 4'hB : 4'hF));
        end

        // Asynchronous reset mid-slot drops a pending load.
        wait_t(FRAME, 3);
        bus.digits_in = 16'h8888; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        wait_t(PS, 5);
        #2 clr_n = 1'b0;
        #1;
        chk("t6_async_seg", 32'(bus.seg_out),     32'(7'h7F));
        chk("t6_async_dig", 32'(bus.dig_en),      32'(4'hF));
        chk("t6_async_dp",  32'(bus.dp_out),      32'(1));
        chk("t6_async_fs",  32'(bus.frame_start), 32'(0));
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        cmp_model();
        for (int k = 1; k <= FRAME + 4; k++) begin
            step();
            if (k == 28 || k == FRAME + 4)
                chk("t6_zero_display", 32'(bus.seg_out), 32'(7'h40));
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bus.load = ($urandom_range(11) == 0);
            if (bus.load) begin
                bus.digits_in = 16'($urandom) >> (4 * $urandom_range(3));
                bus.dp_in     = 4'($urandom);
            end
            if ($urandom_range(59) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(49) == 0) bus.enable   = ~bus.enable;
            step();
        end
        bus.load = 1'b0;
        bus.enable = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
